mux_2to1: RTL and testbench

Registered 2:1 selector for the I2C pass-through datapath. It chooses between two equal-width sources with a single select line and drives the chosen value from an output register. The registered path gives one clock of latency and a defined reset state. Each source carries a valid qualifier, so downstream logic knows when the output holds real data. The block sits between the upstream/downstream line-conditioning logic and the bus drivers.

---
 rtl/mux_2to1.sv | 65 ++++++
 tb/tb_mux_2to1.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// Registered 2:1 selector with per-source valid qualifiers, hold, and a
// select-change pulse. With REG_OUT=0 the data path is purely combinational.
module mux_2to1 #(
  parameter int               WIDTH     = 1,
  parameter bit               REG_OUT   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             i0_valid,
  input  logic             i1_valid,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sel_q,
  output logic             sel_changed
);

  logic [WIDTH-1:0] next_out;
  logic             next_valid;
  logic             started;

  // No X-masking: an unknown sel must propagate to the output.
  assign next_out   = sel ? i1 : i0;
  assign next_valid = sel ? i1_valid : i0_valid;

  // started suppresses the change pulse on the first edge after reset,
  // since sel_q leaves its reset value there without a real transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      sel_changed <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (hold) begin
        sel_changed <= 1'b0;
      end else begin
        sel_q       <= sel;
        sel_changed <= started && (sel != sel_q);
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out       <= RESET_VAL;
          out_valid <= 1'b0;
        end else if (!hold) begin
          out       <= next_out;
          out_valid <= next_valid;
        end
      end
    end else begin : g_comb
      assign out       = next_out;
      assign out_valid = next_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1: a registered 8-bit instance
// and a combinational 8-bit instance share the same stimulus.
module tb_mux_2to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i0, i1;
  logic       sel, i0_valid, i1_valid, hold;

  logic [7:0] out_r, out_c;
  logic       out_valid_r, out_valid_c;
  logic       sel_q_r, sel_q_c;
  logic       sel_changed_r, sel_changed_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(8), .REG_OUT(1'b1), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .sel(sel),
    .i0_valid(i0_valid), .i1_valid(i1_valid), .hold(hold),
    .out(out_r), .out_valid(out_valid_r), .sel_q(sel_q_r),
    .sel_changed(sel_changed_r)
  );

  mux_2to1 #(.WIDTH(8), .REG_OUT(1'b0), .RESET_VAL(8'h00)) dut_comb (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .sel(sel),
    .i0_valid(i0_valid), .i1_valid(i1_valid), .hold(hold),
    .out(out_c), .out_valid(out_valid_c), .sel_q(sel_q_c),
    .sel_changed(sel_changed_c)
  );

  task automatic test_reset();
    rst_n = 1'b0; i0 = 8'h01; i1 = 8'h01; sel = 1'b1;
    i0_valid = 1'b1; i1_valid = 1'b1; hold = 1'b0;
    #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL reset_out: got %h expected %h", out_r, 8'h00); end
    checks++; if (out_valid_r !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected %b", out_valid_r, 1'b0); end
    checks++; if (sel_q_r !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_q: got %b expected %b", sel_q_r, 1'b0); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_changed: got %b expected %b", sel_changed_r, 1'b0); end
    checks++; if (out_c !== 8'h01) begin errors++; $display("[TB] FAIL reset_comb_out: got %h expected %h", out_c, 8'h01); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL reset_held_out: got %h expected %h", out_r, 8'h00); end
  endtask

  task automatic test_first_edge();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h01) begin errors++; $display("[TB] FAIL first_edge_out: got %h expected %h", out_r, 8'h01); end
    checks++; if (sel_q_r !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_sel_q: got %b expected %b", sel_q_r, 1'b1); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL first_edge_no_pulse: got %b expected %b", sel_changed_r, 1'b0); end
  endtask

  task automatic test_select();
    @(negedge clk); sel = 1'b0; i0 = 8'h00; i1 = 8'h00;
    @(posedge clk); #1;
    checks++; if (sel_changed_r !== 1'b1) begin errors++; $display("[TB] FAIL sel0_pulse: got %b expected %b", sel_changed_r, 1'b1); end
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL sel0_out: got %h expected %h", out_r, 8'h00); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL sel0_pulse_end: got %b expected %b", sel_changed_r, 1'b0); end

    @(negedge clk); i0 = 8'h01; i1 = 8'h00;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_r !== 8'h01) begin errors++; $display("[TB] FAIL pass_i0_out: got %h expected %h", out_r, 8'h01); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL pass_i0_no_pulse: got %b expected %b", sel_changed_r, 1'b0); end

    @(negedge clk); sel = 1'b1;
    #1;
    checks++; if (out_r !== 8'h01) begin errors++; $display("[TB] FAIL switch_latency: got %h expected %h", out_r, 8'h01); end
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL switch_out: got %h expected %h", out_r, 8'h00); end
    checks++; if (sel_changed_r !== 1'b1) begin errors++; $display("[TB] FAIL switch_pulse: got %b expected %b", sel_changed_r, 1'b1); end
    @(posedge clk); #1;
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL switch_pulse_width: got %b expected %b", sel_changed_r, 1'b0); end
  endtask

  task automatic test_hold();
    @(negedge clk); i0 = 8'h00; i1 = 8'h01;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h01) begin errors++; $display("[TB] FAIL hold_pre_out: got %h expected %h", out_r, 8'h01); end
    @(negedge clk); hold = 1'b1; sel = 1'b0; i0_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (out_r !== 8'h01) begin errors++; $display("[TB] FAIL hold_out: got %h expected %h", out_r, 8'h01); end
    checks++; if (out_valid_r !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %b expected %b", out_valid_r, 1'b1); end
    checks++; if (sel_q_r !== 1'b1) begin errors++; $display("[TB] FAIL hold_sel_q: got %b expected %b", sel_q_r, 1'b1); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_pulse: got %b expected %b", sel_changed_r, 1'b0); end
    checks++; if (out_c !== 8'h00) begin errors++; $display("[TB] FAIL hold_comb_out: got %h expected %h", out_c, 8'h00); end
    @(negedge clk); hold = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL release_out: got %h expected %h", out_r, 8'h00); end
    checks++; if (out_valid_r !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected %b", out_valid_r, 1'b0); end
    checks++; if (sel_q_r !== 1'b0) begin errors++; $display("[TB] FAIL release_sel_q: got %b expected %b", sel_q_r, 1'b0); end
    checks++; if (sel_changed_r !== 1'b1) begin errors++; $display("[TB] FAIL release_pulse: got %b expected %b", sel_changed_r, 1'b1); end
  endtask

  task automatic test_valid();
    @(negedge clk); i0 = 8'hA5; i1 = 8'h3C; i1_valid = 1'b0; i0_valid = 1'b0; sel = 1'b1;
    #1;
    checks++; if (out_c !== 8'h3C) begin errors++; $display("[TB] FAIL comb_out_i1: got %h expected %h", out_c, 8'h3C); end
    checks++; if (out_valid_c !== 1'b0) begin errors++; $display("[TB] FAIL comb_valid_i1: got %b expected %b", out_valid_c, 1'b0); end
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h3C) begin errors++; $display("[TB] FAIL valid_i1_out: got %h expected %h", out_r, 8'h3C); end
    checks++; if (out_valid_r !== 1'b0) begin errors++; $display("[TB] FAIL valid_i1_valid: got %b expected %b", out_valid_r, 1'b0); end
    @(negedge clk); sel = 1'b0; i0_valid = 1'b1;
    #1;
    checks++; if (out_c !== 8'hA5) begin errors++; $display("[TB] FAIL comb_out_i0: got %h expected %h", out_c, 8'hA5); end
    checks++; if (out_valid_c !== 1'b1) begin errors++; $display("[TB] FAIL comb_valid_i0: got %b expected %b", out_valid_c, 1'b1); end
    @(posedge clk); #1;
    checks++; if (out_r !== 8'hA5) begin errors++; $display("[TB] FAIL valid_i0_out: got %h expected %h", out_r, 8'hA5); end
    checks++; if (out_valid_r !== 1'b1) begin errors++; $display("[TB] FAIL valid_i0_valid: got %b expected %b", out_valid_r, 1'b1); end
    checks++; if (sel_q_c !== 1'b0) begin errors++; $display("[TB] FAIL comb_sel_q: got %b expected %b", sel_q_c, 1'b0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); sel = 1'b1; i1 = 8'h77; i1_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h77) begin errors++; $display("[TB] FAIL b2b_first_out: got %h expected %h", out_r, 8'h77); end
    @(negedge clk); sel = 1'b0; i0 = 8'h12;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'h12) begin errors++; $display("[TB] FAIL b2b_second_out: got %h expected %h", out_r, 8'h12); end
    checks++; if (sel_changed_r !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_pulse: got %b expected %b", sel_changed_r, 1'b1); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); sel = 1'b1; i1 = 8'hFF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_r !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_out: got %h expected %h", out_r, 8'h00); end
    checks++; if (out_valid_r !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b expected %b", out_valid_r, 1'b0); end
    checks++; if (sel_q_r !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_sel_q: got %b expected %b", sel_q_r, 1'b0); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_pulse: got %b expected %b", sel_changed_r, 1'b0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_r !== 8'hFF) begin errors++; $display("[TB] FAIL post_reset_out: got %h expected %h", out_r, 8'hFF); end
    checks++; if (sel_changed_r !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_no_pulse: got %b expected %b", sel_changed_r, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_select();
    test_hold();
    test_valid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
